// File: rtl/sample_gain.sv
// rtl/sample_gain.sv - offset-binary x1..x16 gain restore with saturation and optional auto-ranging
// Optional saturation counter enabled by defining SAMPLE_GAIN_SATCNT_EN.
module sample_gain #(
    parameter int DATA_W   = 14,
    parameter int MID      = 4096,
    parameter int MAX_CODE = 8191,
    parameter int WIN_LOG2 = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [3:0]        Sel_gain,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] ADC_in,
    output logic              out_valid,
    output logic [DATA_W-1:0] ADC_out,
    output logic              sat_flag,
    output logic [2:0]        gain_cur
`ifdef SAMPLE_GAIN_SATCNT_EN
    ,
    output logic [15:0]       sat_count
`endif
);

    localparam int SW = DATA_W + 1;
    localparam int PW = DATA_W + 6;

    localparam logic signed [SW-1:0] MID_S = SW'(MID);
    localparam logic signed [PW-1:0] P_HI  = PW'(MAX_CODE - MID);
    localparam logic signed [PW-1:0] P_LO  = PW'(-MID);
    localparam logic signed [PW-1:0] P_MID = PW'(MID);
    localparam logic [PW-1:0]        LIM   = PW'(MID - 1);

    typedef enum logic [1:0] {
        ST_MANUAL,
        ST_MEASURE,
        ST_ADJUST
    } state_t;

    state_t                state_q, state_nx;
    logic [2:0]            k_q, k_nx;
    logic [WIN_LOG2-1:0]   count_q, count_nx;
    logic [DATA_W-1:0]     peak_q, peak_nx;

    logic signed [SW-1:0]  s_in;
    logic [DATA_W-1:0]     s_abs;
    logic                  auto_sel;
    logic [PW-1:0]         pk_shift, pk_shift1;

    logic signed [SW-1:0]  s1_q;
    logic                  v1_q;
    logic signed [PW-1:0]  p_ext, p_shift, p_clamp;
    logic [DATA_W-1:0]     out_nx;
    logic                  sat_nx;

    function automatic logic [2:0] decode_gain(input logic [3:0] sel);
        case (sel)
            4'b0000: decode_gain = 3'd1;
            4'b0010: decode_gain = 3'd2;
            4'b0100: decode_gain = 3'd3;
            4'b1000: decode_gain = 3'd4;
            default: decode_gain = 3'd0;
        endcase
    endfunction

    assign s_in     = $signed({1'b0, ADC_in}) - MID_S;
    assign s_abs    = s_in[SW-1] ? DATA_W'(-s_in) : s_in[DATA_W-1:0];
    assign auto_sel = (Sel_gain == 4'b1111);
    assign gain_cur = k_q;

    // Window peak scaled by the current and the next-higher gain, compared against full half-scale.
    assign pk_shift  = PW'(peak_q) << k_q;
    assign pk_shift1 = PW'(peak_q) << (k_q + 3'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_MANUAL;
            k_q     <= 3'd0;
            count_q <= '0;
            peak_q  <= '0;
        end else begin
            state_q <= state_nx;
            k_q     <= k_nx;
            count_q <= count_nx;
            peak_q  <= peak_nx;
        end
    end

    always_comb begin
        state_nx = state_q;
        k_nx     = k_q;
        count_nx = count_q;
        peak_nx  = peak_q;
        if (!auto_sel) begin
            state_nx = ST_MANUAL;
            k_nx     = decode_gain(Sel_gain);
            count_nx = '0;
            peak_nx  = '0;
        end else begin
            case (state_q)
                ST_MANUAL: begin
                    state_nx = ST_MEASURE;
                    k_nx     = 3'd0;
                    count_nx = '0;
                    peak_nx  = '0;
                end
                ST_MEASURE: begin
                    if (in_valid) begin
                        peak_nx  = (s_abs > peak_q) ? s_abs : peak_q;
                        count_nx = count_q + WIN_LOG2'(1);
                        if (count_q == '1) begin
                            state_nx = ST_ADJUST;
                        end
                    end
                end
                ST_ADJUST: begin
                    if (pk_shift > LIM && k_q != 3'd0) begin
                        k_nx = k_q - 3'd1;
                    end else if (pk_shift1 <= LIM && k_q < 3'd4) begin
                        k_nx = k_q + 3'd1;
                    end
                    // A sample landing here opens the next window.
                    peak_nx  = in_valid ? s_abs : '0;
                    count_nx = in_valid ? WIN_LOG2'(1) : '0;
                    state_nx = ST_MEASURE;
                end
                default: begin
                    state_nx = ST_MANUAL;
                end
            endcase
        end
    end

    always_comb begin
        p_ext   = PW'(s1_q);
        p_shift = p_ext <<< k_q;
        p_clamp = p_shift;
        sat_nx  = 1'b0;
        if (p_shift > P_HI) begin
            p_clamp = P_HI;
            sat_nx  = 1'b1;
        end else if (p_shift < P_LO) begin
            p_clamp = P_LO;
            sat_nx  = 1'b1;
        end
        out_nx = DATA_W'(p_clamp + P_MID);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q      <= '0;
            v1_q      <= 1'b0;
            out_valid <= 1'b0;
            ADC_out   <= DATA_W'(MID);
            sat_flag  <= 1'b0;
        end else begin
            v1_q      <= in_valid;
            out_valid <= v1_q;
            if (in_valid) begin
                s1_q <= s_in;
            end
            if (v1_q) begin
                ADC_out  <= out_nx;
                sat_flag <= sat_nx;
            end
        end
    end

`ifdef SAMPLE_GAIN_SATCNT_EN
    logic [3:0] sel_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_q     <= 4'd0;
            sat_count <= 16'd0;
        end else begin
            sel_q <= Sel_gain;
            if (Sel_gain != sel_q) begin
                sat_count <= 16'd0;
            end else if (out_valid && sat_flag && sat_count != 16'hFFFF) begin
                sat_count <= sat_count + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_sample_gain.sv
// tb/tb_sample_gain.sv - directed self-checking bench for sample_gain (auto window 16 samples)
module tb_sample_gain;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  sel;
    logic        in_valid;
    logic [13:0] adc_in;
    logic        out_valid;
    logic [13:0] adc_out;
    logic        sat_flag;
    logic [2:0]  gain_cur;
`ifdef SAMPLE_GAIN_SATCNT_EN
    logic [15:0] sat_count;
`endif

    int n_cmp = 0;
    int n_err = 0;
    int sat_hits_hi;
    int sat_hits_lo;

    always #5 clk = ~clk;

    sample_gain #(
        .DATA_W   (14),
        .MID      (4096),
        .MAX_CODE (8191),
        .WIN_LOG2 (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .Sel_gain  (sel),
        .in_valid  (in_valid),
        .ADC_in    (adc_in),
        .out_valid (out_valid),
        .ADC_out   (adc_out),
        .sat_flag  (sat_flag),
        .gain_cur  (gain_cur)
`ifdef SAMPLE_GAIN_SATCNT_EN
        ,
        .sat_count (sat_count)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [13:0] tri_wave(input int i, input int lo, input int step);
        int ph;
        ph = i % 16;
        return 14'((ph <= 8) ? lo + step * ph : lo + step * (16 - ph));
    endfunction

    task automatic one_shot(input logic [3:0] s, input logic [13:0] d, input int exp_out,
                            input int exp_sat, input int exp_k, input string tag);
        @(negedge clk);
        sel = s;
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        adc_in = d;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_out"}, 32'(adc_out), 32'(exp_out));
        chk({tag, "_sat"}, 32'(sat_flag), 32'(exp_sat));
        chk({tag, "_k"}, 32'(gain_cur), 32'(exp_k));
    endtask

    initial begin
        rst_n = 1'b0;
        sel = 4'b0101;
        in_valid = 1'b0;
        adc_in = 14'd0;
        repeat (2) @(negedge clk);
        chk("rst_out", 32'(adc_out), 32'd4096);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_sat", 32'(sat_flag), 32'd0);
        chk("rst_k", 32'(gain_cur), 32'd0);
        rst_n = 1'b1;

        one_shot(4'b0010, 14'd4196, 4496, 0, 2, "x4");
        one_shot(4'b1000, 14'd8191, 8191, 1, 4, "x16_top");
        one_shot(4'b1000, 14'd0, 0, 1, 4, "x16_bot");
        one_shot(4'b0101, 14'd1234, 1234, 0, 0, "undef_x1");
        one_shot(4'b0000, 14'd4000, 3904, 0, 1, "x2_neg");
        one_shot(4'b0100, 14'd4608, 8191, 1, 3, "x8_clip");
        one_shot(4'b0100, 14'd4607, 8184, 0, 3, "x8_edge");

        repeat (3) @(negedge clk);
        chk("hold_valid", 32'(out_valid), 32'd0);
        chk("hold_out", 32'(adc_out), 32'd8184);

        // Auto ranging: 16-sample windows, peak 200 then peak 3000.
        sel = 4'b1111;
        repeat (2) @(negedge clk);
        sat_hits_hi = 0;
        sat_hits_lo = 0;
        for (int i = 0; i < 224; i++) begin
            @(negedge clk);
            if (out_valid && sat_flag && i >= 130 && i < 178) sat_hits_hi++;
            if (out_valid && sat_flag && i >= 190) sat_hits_lo++;
            if (i < 112 && i % 16 == 8)
                chk($sformatf("auto_up_w%0d", i / 16), 32'(gain_cur), 32'((i / 16 > 4) ? 4 : i / 16));
            if (i >= 128 && i % 16 == 8)
                chk($sformatf("auto_dn_w%0d", i / 16), 32'(gain_cur),
                    32'((3 - (i - 128) / 16 < 0) ? 0 : 3 - (i - 128) / 16));
            adc_in = (i < 112) ? tri_wave(i, 3896, 50) : tri_wave(i, 1096, 375);
            in_valid = 1'b1;
        end
        @(negedge clk);
        in_valid = 1'b0;
        chk("auto_sat_seen", 32'(sat_hits_hi > 0), 32'd1);
        chk("auto_sat_k0", 32'(sat_hits_lo), 32'd0);

        sel = 4'b0010;
        repeat (2) @(negedge clk);
        chk("back_manual_k", 32'(gain_cur), 32'd2);

        // Reset in the middle of an auto window.
        sel = 4'b1111;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            adc_in = tri_wave(i, 3896, 50);
            in_valid = 1'b1;
        end
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out", 32'(adc_out), 32'd4096);
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_sat", 32'(sat_flag), 32'd0);
        chk("mid_rst_k", 32'(gain_cur), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 26; i++) begin
            @(negedge clk);
            if (i == 8) chk("restart_w0", 32'(gain_cur), 32'd0);
            if (i == 24) chk("restart_w1", 32'(gain_cur), 32'd1);
            adc_in = tri_wave(i, 3896, 50);
            in_valid = 1'b1;
        end
        @(negedge clk);
        in_valid = 1'b0;

`ifdef SAMPLE_GAIN_SATCNT_EN
        sel = 4'b1000;
        repeat (2) @(negedge clk);
        chk("satcnt_clr0", 32'(sat_count), 32'd0);
        for (int i = 0; i < 70000; i++) begin
            @(negedge clk);
            adc_in = 14'd8191;
            in_valid = 1'b1;
        end
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        chk("satcnt_top", 32'(sat_count), 32'hFFFF);
        sel = 4'b0010;
        repeat (2) @(negedge clk);
        chk("satcnt_clr1", 32'(sat_count), 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
